// File: rtl/mux_2to1.sv
// Registered 2:1 bus multiplexer with a one-entry valid/ready output stage.
// Optional build macro: MUX2TO1_SWITCH_CNT_EN adds the sel_switch_cnt port and counter.
module mux_2to1 #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic [BUS_WIDTH-1:0] in0,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 out_valid,
`ifdef MUX2TO1_SWITCH_CNT_EN
  output logic [15:0]          sel_switch_cnt,
`endif
  input  logic                 out_ready
);

  // Handshake: a word moves on any cycle where valid && ready are both high.
  // On the input side, ready means the output register is empty or draining
  // this cycle; it never looks at in_valid. On the output side, out is frozen
  // while out_valid is high and out_ready is low.

  logic [BUS_WIDTH-1:0] r_out;
  logic                 r_out_valid;
  logic [BUS_WIDTH-1:0] w_next;
  logic                 w_accept;
  logic                 w_drain;

  assign w_next   = sel ? in1 : in0;
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_next;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

`ifdef MUX2TO1_SWITCH_CNT_EN
  logic [15:0] r_switch_cnt;
  logic        r_last_sel;

  // The first accept after reset compares against a last-sel of 0; wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_switch_cnt <= 16'h0000;
      r_last_sel   <= 1'b0;
    end else if (w_accept) begin
      r_last_sel <= sel;
      if (sel != r_last_sel) begin
        r_switch_cnt <= r_switch_cnt + 16'h0001;
      end
    end
  end

  assign sel_switch_cnt = r_switch_cnt;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed self-checking bench for mux_2to1 (16-bit bus).
// The switch-counter checks are built only when MUX2TO1_SWITCH_CNT_EN is defined.
module tb_mux_2to1;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX2TO1_SWITCH_CNT_EN
  logic [15:0] sel_switch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mux_2to1 #(.BUS_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .in0       (in0),
    .in1       (in1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
`ifdef MUX2TO1_SWITCH_CNT_EN
    .sel_switch_cnt (sel_switch_cnt),
`endif
    .out_ready (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef MUX2TO1_SWITCH_CNT_EN
    check(tag, {16'h0, sel_switch_cnt}, {16'h0, exp});
`endif
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b1;
    in0       = 16'h0005;
    in1       = 16'h000A;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    // reset held two cycles with in_valid high
    step();
    step();
    check("rst_out",      {16'h0, out}, 32'h0000);
    check("rst_valid",    {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check_cnt("rst_cnt", 16'h0000);

    // select sequence
    rst = 1'b0;
    sel = 1'b1; step(); check("seq0_out", {16'h0, out}, 32'h000A);
    check("seq0_valid", {31'h0, out_valid}, 32'h1);
    sel = 1'b0; step(); check("seq1_out", {16'h0, out}, 32'h0005);
    sel = 1'b1; step(); check("seq2_out", {16'h0, out}, 32'h000A);
    in0 = 16'h0003; sel = 1'b1; step(); check("seq3_out", {16'h0, out}, 32'h000A);
    in1 = 16'h000C; sel = 1'b1; step(); check("seq4_out", {16'h0, out}, 32'h000C);
    check_cnt("seq_cnt", 16'd3);

    // back-pressure: load 0x000A then stall three cycles with changing inputs
    in1 = 16'h000A; sel = 1'b1; step();
    check("bp_load", {16'h0, out}, 32'h000A);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_comb", {31'h0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sel = ~sel;
      in0 = 16'h1111 + 16'(i);
      in1 = 16'h2222 + 16'(i);
      step();
      check("bp_hold_out",   {16'h0, out}, 32'h000A);
      check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      check("bp_in_ready",   {31'h0, in_ready}, 32'h0);
    end
    check_cnt("bp_cnt", 16'd3);
    // release: in_ready follows out_ready combinationally, next word one cycle later
    sel = 1'b0; in0 = 16'h1111; in1 = 16'h2222;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'h0, in_ready}, 32'h1);
    step();
    check("bp_release_out",   {16'h0, out}, 32'h1111);
    check("bp_release_valid", {31'h0, out_valid}, 32'h1);
    check_cnt("bp_release_cnt", 16'd4);

    // bubble: no new input, downstream drains
    in_valid = 1'b0; sel = 1'b1; in1 = 16'hDEAD;
    step();
    check("bubble_valid",    {31'h0, out_valid}, 32'h0);
    check("bubble_out_hold", {16'h0, out}, 32'h1111);
    check("bubble_in_ready", {31'h0, in_ready}, 32'h1);
    check_cnt("bubble_cnt", 16'd4);

    // mid-stream reset with an accept pending
    in_valid = 1'b1; sel = 1'b1; in1 = 16'h00BE;
    step();
    check("pre_rst_out", {16'h0, out}, 32'h00BE);
    check_cnt("pre_rst_cnt", 16'd5);
    rst = 1'b1; in1 = 16'h0077;
    step();
    check("mid_rst_out",   {16'h0, out}, 32'h0000);
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check_cnt("mid_rst_cnt", 16'd0);
    rst = 1'b0;

`ifdef MUX2TO1_SWITCH_CNT_EN
    // wrap: 65536 alternating accepts starting from sel=1 (last sel is 0 after reset)
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      sel = ~i[0];
      step();
    end
    check_cnt("wrap_ffff", 16'hFFFF);
    sel = 1'b0; in0 = 16'h4242;
    step();
    check_cnt("wrap_zero", 16'h0000);
    check("wrap_out", {16'h0, out}, 32'h4242);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
